id_operand_stage: RTL and testbench

- Decode/operand-fetch stage sitting directly upstream of the register file and downstream of instruction decode.
- Drives the two register-file read addresses and resolves operands with forwarding: EX > MEM > WB > file.
- Detects load-use hazards and inserts a bubble.
- Latches operands and control into the ID/EX pipeline register consumed by the execute stage.

---
 rtl/id_operand_stage_pkg.sv | 23 ++
 rtl/id_operand_stage_operand_fwd_mux.sv | 61 ++++++
 rtl/id_operand_stage.sv | 197 +++++++++++++++++++
 tb/tb_id_operand_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the ID/operand-fetch stage.
// Holds the default widths, the hardwired-zero register index and the
// encoding of the operand forward-select used by operand_fwd_mux.
package id_operand_stage_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_CTRL_WIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 32;

    // Architectural register that always reads as zero
    localparam int unsigned REG_ZERO = 0;

    // Operand source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/id_operand_stage_operand_fwd_mux.sv
// Purely combinational operand resolver for one source register.
// Picks the newest in-flight value for rs: zero register, EX result,
// MEM result, WB write data, then register-file read data.
// Ports:
//   rs                          source register address
//   ex_fwd_en/ex_rd/ex_result   instruction held in the ID/EX register
//   mem_fwd_en/mem_rd/mem_result MEM-stage writer
//   wb_we/wb_addr/wb_data       register-file write port this cycle
//   rf_data                     asynchronous register-file read data
//   operand_c                   resolved operand
module operand_fwd_mux
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH
) (
    input  logic [addr_width-1:0] rs,
    input  logic                  ex_fwd_en,
    input  logic [addr_width-1:0] ex_rd,
    input  logic [data_width-1:0] ex_result,
    input  logic                  mem_fwd_en,
    input  logic [addr_width-1:0] mem_rd,
    input  logic [data_width-1:0] mem_result,
    input  logic                  wb_we,
    input  logic [addr_width-1:0] wb_addr,
    input  logic [data_width-1:0] wb_data,
    input  logic [data_width-1:0] rf_data,
    output logic [data_width-1:0] operand_c
);

    fwd_sel_e sel_c;

    // Select: checking rs against zero first means a writer of register 0
    // can never be forwarded from any stage.
    always_comb begin
        sel_c = FWD_RF;
        if (rs == addr_width'(REG_ZERO)) begin
            sel_c = FWD_ZERO;
        end else if (ex_fwd_en && (ex_rd == rs)) begin
            sel_c = FWD_EX;
        end else if (mem_fwd_en && (mem_rd == rs)) begin
            sel_c = FWD_MEM;
        end else if (wb_we && (wb_addr == rs)) begin
            // File write lands at the edge, so bypass it for this read
            sel_c = FWD_WB;
        end
    end

    // Operand data mux driven by the select
    always_comb begin
        operand_c = rf_data;
        case (sel_c)
            FWD_ZERO: operand_c = '0;
            FWD_EX:   operand_c = ex_result;
            FWD_MEM:  operand_c = mem_result;
            FWD_WB:   operand_c = wb_data;
            default:  operand_c = rf_data;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: drives register-file read addresses,
// resolves both operands with EX > MEM > WB > file forwarding, inserts a
// bubble on load-use hazards and latches the ID/EX pipeline register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_*                        decoded instruction from upstream
//   in_ready                    instruction accepted this cycle (combinational)
//   rf_r0addr/rf_r1addr         register-file read addresses (combinational)
//   rf_r0data/rf_r1data         register-file read data
//   ex_result                   ALU result of the held instruction
//   mem_*                       MEM-stage writer
//   wb_*                        register-file write port
//   ex_hold, flush              execute stall, squash of the latching slot
//   out_*                       registered ID/EX fields
//   stall_cnt                   saturating count of load-use bubbles
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH,
    parameter int unsigned ctrl_width = DEF_CTRL_WIDTH,
    parameter int unsigned cnt_width  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [addr_width-1:0] in_rs0,
    input  logic [addr_width-1:0] in_rs1,
    input  logic                  in_use0,
    input  logic                  in_use1,
    input  logic [addr_width-1:0] in_rd,
    input  logic                  in_we,
    input  logic                  in_is_load,
    input  logic [ctrl_width-1:0] in_ctrl,
    output logic                  in_ready,
    output logic [addr_width-1:0] rf_r0addr,
    output logic [addr_width-1:0] rf_r1addr,
    input  logic [data_width-1:0] rf_r0data,
    input  logic [data_width-1:0] rf_r1data,
    input  logic [data_width-1:0] ex_result,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [addr_width-1:0] mem_rd,
    input  logic [data_width-1:0] mem_result,
    input  logic                  wb_we,
    input  logic [addr_width-1:0] wb_addr,
    input  logic [data_width-1:0] wb_data,
    input  logic                  ex_hold,
    input  logic                  flush,
    output logic                  out_valid,
    output logic                  out_we,
    output logic                  out_is_load,
    output logic [addr_width-1:0] out_rd,
    output logic [data_width-1:0] out_op0,
    output logic [data_width-1:0] out_op1,
    output logic [ctrl_width-1:0] out_ctrl,
    output logic [cnt_width-1:0]  stall_cnt
);

    logic                  out_valid_q,   out_valid_d;
    logic                  out_we_q,      out_we_d;
    logic                  out_is_load_q, out_is_load_d;
    logic [addr_width-1:0] out_rd_q,      out_rd_d;
    logic [data_width-1:0] out_op0_q,     out_op0_d;
    logic [data_width-1:0] out_op1_q,     out_op1_d;
    logic [ctrl_width-1:0] out_ctrl_q,    out_ctrl_d;
    logic [cnt_width-1:0]  stall_cnt_q,   stall_cnt_d;

    logic                  ex_fwd_en_c;
    logic                  mem_fwd_en_c;
    logic                  load_use_c;
    logic                  hit0_c;
    logic                  hit1_c;
    logic [data_width-1:0] op0_c;
    logic [data_width-1:0] op1_c;

    // Register-file reads go straight out from the decoded sources
    assign rf_r0addr = in_rs0;
    assign rf_r1addr = in_rs1;

    assign ex_fwd_en_c  = out_valid_q & out_we_q;
    assign mem_fwd_en_c = mem_valid & mem_we;

    operand_fwd_mux #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_fwd0 (
        .rs         (in_rs0),
        .ex_fwd_en  (ex_fwd_en_c),
        .ex_rd      (out_rd_q),
        .ex_result  (ex_result),
        .mem_fwd_en (mem_fwd_en_c),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_data    (rf_r0data),
        .operand_c  (op0_c)
    );

    operand_fwd_mux #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_fwd1 (
        .rs         (in_rs1),
        .ex_fwd_en  (ex_fwd_en_c),
        .ex_rd      (out_rd_q),
        .ex_result  (ex_result),
        .mem_fwd_en (mem_fwd_en_c),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_data    (rf_r1data),
        .operand_c  (op1_c)
    );

    // Load-use: the held load's data is not ready until it reaches MEM
    assign hit0_c     = in_use0 & (in_rs0 == out_rd_q);
    assign hit1_c     = in_use1 & (in_rs1 == out_rd_q);
    assign load_use_c = in_valid & out_valid_q & out_is_load_q
                      & (out_rd_q != addr_width'(REG_ZERO))
                      & (hit0_c | hit1_c);

    assign in_ready = ~load_use_c & ~ex_hold;

    // ID/EX next-state: flush > hold > bubble > accept
    always_comb begin
        out_valid_d   = out_valid_q;
        out_we_d      = out_we_q;
        out_is_load_d = out_is_load_q;
        out_rd_d      = out_rd_q;
        out_op0_d     = out_op0_q;
        out_op1_d     = out_op1_q;
        out_ctrl_d    = out_ctrl_q;
        if (flush || (!ex_hold && load_use_c)) begin
            out_valid_d   = 1'b0;
            out_we_d      = 1'b0;
            out_is_load_d = 1'b0;
            out_rd_d      = '0;
            out_op0_d     = '0;
            out_op1_d     = '0;
            out_ctrl_d    = '0;
        end else if (!ex_hold) begin
            out_valid_d   = in_valid;
            out_we_d      = in_we;
            out_is_load_d = in_is_load;
            out_rd_d      = in_rd;
            out_op0_d     = op0_c;
            out_op1_d     = op1_c;
            out_ctrl_d    = in_ctrl;
        end
    end

    // Bubble counter, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use_c && !ex_hold && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + cnt_width'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_we_q      <= 1'b0;
            out_is_load_q <= 1'b0;
            out_rd_q      <= '0;
            out_op0_q     <= '0;
            out_op1_q     <= '0;
            out_ctrl_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_we_q      <= out_we_d;
            out_is_load_q <= out_is_load_d;
            out_rd_q      <= out_rd_d;
            out_op0_q     <= out_op0_d;
            out_op1_q     <= out_op1_d;
            out_ctrl_q    <= out_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_we      = out_we_q;
    assign out_is_load = out_is_load_q;
    assign out_rd      = out_rd_q;
    assign out_op0     = out_op0_q;
    assign out_op1     = out_op1_q;
    assign out_ctrl    = out_ctrl_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_operand_stage;

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned NW   = 4;   // narrow counter so saturation is reachable
    localparam int unsigned NREG = 16;
    localparam int unsigned MAXC = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_use0, in_use1, in_we, in_is_load;
    logic [AW-1:0] in_rs0, in_rs1, in_rd;
    logic [CW-1:0] in_ctrl;
    logic          in_ready;
    logic [AW-1:0] rf_r0addr, rf_r1addr;
    logic [DW-1:0] rf_r0data, rf_r1data;
    logic [DW-1:0] ex_result;
    logic          mem_valid, mem_we;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          ex_hold, flush;
    logic          out_valid, out_we, out_is_load;
    logic [AW-1:0] out_rd;
    logic [DW-1:0] out_op0, out_op1;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    // Register-file contents (register 0 deliberately non-zero)
    logic [DW-1:0] rf_mem [NREG];
    assign rf_r0data = rf_mem[rf_r0addr];
    assign rf_r1data = rf_mem[rf_r1addr];

    always #5 clk = ~clk;

    id_operand_stage #(
        .data_width (DW),
        .addr_width (AW),
        .ctrl_width (CW),
        .cnt_width  (NW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_rs0      (in_rs0),
        .in_rs1      (in_rs1),
        .in_use0     (in_use0),
        .in_use1     (in_use1),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .in_is_load  (in_is_load),
        .in_ctrl     (in_ctrl),
        .in_ready    (in_ready),
        .rf_r0addr   (rf_r0addr),
        .rf_r1addr   (rf_r1addr),
        .rf_r0data   (rf_r0data),
        .rf_r1data   (rf_r1data),
        .ex_result   (ex_result),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_result  (mem_result),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_we      (out_we),
        .out_is_load (out_is_load),
        .out_rd      (out_rd),
        .out_op0     (out_op0),
        .out_op1     (out_op1),
        .out_ctrl    (out_ctrl),
        .stall_cnt   (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model of the ID/EX register contents and the raw bubble count
    logic          m_valid, m_we, m_is_load;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_op0, m_op1;
    logic [CW-1:0] m_ctrl;
    int unsigned   m_stalls;

    task automatic chk(input string tag, input string fld,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (m_valid && m_we && m_rd == rs) return ex_result;
        if (mem_valid && mem_we && mem_rd == rs) return mem_result;
        if (wb_we && wb_addr == rs) return wb_data;
        return rf_mem[rs];
    endfunction

    function automatic logic model_load_use();
        if (!(in_valid && m_valid && m_is_load) || m_rd == 0) return 1'b0;
        return (in_use0 && in_rs0 == m_rd) || (in_use1 && in_rs1 == m_rd);
    endfunction

    function automatic logic [63:0] exp_cnt();
        return 64'((m_stalls > MAXC) ? MAXC : m_stalls);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_is_load = 0; m_rd = '0;
        m_op0 = '0; m_op1 = '0; m_ctrl = '0; m_stalls = 0;
    endtask

    task automatic set_idle();
        in_valid = 0; in_rs0 = '0; in_rs1 = '0; in_use0 = 0; in_use1 = 0;
        in_rd = '0; in_we = 0; in_is_load = 0; in_ctrl = '0;
        ex_result = '0; mem_valid = 0; mem_we = 0; mem_rd = '0; mem_result = '0;
        wb_we = 0; wb_addr = '0; wb_data = '0; ex_hold = 0; flush = 0;
    endtask

    // One clock: predict from current inputs, cross the edge, compare
    task automatic tick(input string tag);
        logic          lu, n_valid, n_we, n_ld;
        logic [AW-1:0] n_rd;
        logic [DW-1:0] n_op0, n_op1;
        logic [CW-1:0] n_ctrl;
        logic          w_en;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        #1;
        lu = model_load_use();
        chk(tag, "in_ready", 64'(in_ready), 64'(!lu && !ex_hold));
        chk(tag, "rf_r1addr", 64'(rf_r1addr), 64'(in_rs1));
        n_valid = m_valid; n_we = m_we; n_ld = m_is_load; n_rd = m_rd;
        n_op0 = m_op0; n_op1 = m_op1; n_ctrl = m_ctrl;
        if (flush || (!ex_hold && lu)) begin
            n_valid = 0;
        end else if (!ex_hold) begin
            n_valid = in_valid; n_we = in_we; n_ld = in_is_load; n_rd = in_rd;
            n_op0 = resolve(in_rs0); n_op1 = resolve(in_rs1); n_ctrl = in_ctrl;
        end
        if (lu && !ex_hold && !flush) m_stalls++;
        w_en = wb_we; w_a = wb_addr; w_d = wb_data;
        @(posedge clk);
        #1;
        if (w_en && w_a != 0) rf_mem[w_a] = w_d;
        m_valid = n_valid; m_we = n_we; m_is_load = n_ld; m_rd = n_rd;
        m_op0 = n_op0; m_op1 = n_op1; m_ctrl = n_ctrl;
        chk(tag, "out_valid", 64'(out_valid), 64'(m_valid));
        chk(tag, "stall_cnt", 64'(stall_cnt), exp_cnt());
        if (m_valid) begin
            chk(tag, "out_we", 64'(out_we), 64'(m_we));
            chk(tag, "out_is_load", 64'(out_is_load), 64'(m_is_load));
            chk(tag, "out_rd", 64'(out_rd), 64'(m_rd));
            chk(tag, "out_op0", out_op0, m_op0);
            chk(tag, "out_op1", out_op1, m_op1);
            chk(tag, "out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        end
    endtask

    // Asynchronous reset asserted between edges, checked before any edge
    task automatic async_reset(input string tag);
        rst_n = 0;
        #1;
        model_clear();
        chk(tag, "out_valid", 64'(out_valid), 64'd0);
        chk(tag, "out_op0", out_op0, 64'd0);
        chk(tag, "out_rd", 64'(out_rd), 64'd0);
        chk(tag, "stall_cnt", 64'(stall_cnt), 64'd0);
        chk(tag, "in_ready", 64'(in_ready), 64'(!ex_hold));
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic issue_load(input logic [AW-1:0] rd);
        set_idle();
        in_valid = 1; in_rd = rd; in_we = 1; in_is_load = 1;
        tick("load");
    endtask

    initial begin
        set_idle();
        model_clear();
        rst_n = 0;
        for (int i = 0; i < int'(NREG); i++) rf_mem[i] = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "out_valid", 64'(out_valid), 64'd0);
        chk("reset", "out_op0", out_op0, 64'd0);
        chk("reset", "stall_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1;

        // Basic register-file path
        rf_mem[3] = 64'h11; rf_mem[5] = 64'h22;
        in_valid = 1; in_rs0 = 3; in_rs1 = 5; in_use0 = 1; in_use1 = 1;
        in_rd = 7; in_we = 1; in_ctrl = 8'h5C;
        #1;
        chk("basic", "rf_r0addr", 64'(rf_r0addr), 64'd3);
        tick("basic");
        chk("basic", "op0", out_op0, 64'h11);
        chk("basic", "op1", out_op1, 64'h22);
        chk("basic", "rd", 64'(out_rd), 64'd7);
        chk("basic", "valid", 64'(out_valid), 64'd1);

        // Forwarding priority EX > MEM > WB > file
        set_idle();
        in_valid = 1; in_rd = 4; in_we = 1;
        tick("fwd_setup");
        in_rs0 = 4; in_use0 = 1; in_rd = 9;
        ex_result = 64'hA;
        mem_valid = 1; mem_we = 1; mem_rd = 4; mem_result = 64'hB;
        wb_we = 1; wb_addr = 4; wb_data = 64'hC;
        rf_mem[4] = 64'h77;
        tick("fwd_ex");
        chk("fwd_ex", "op0", out_op0, 64'hA);
        tick("fwd_mem");
        chk("fwd_mem", "op0", out_op0, 64'hB);
        rf_mem[4] = 64'h77; mem_valid = 0;
        tick("fwd_wb");
        chk("fwd_wb", "op0", out_op0, 64'hC);
        rf_mem[4] = 64'h77; wb_we = 0;
        tick("fwd_rf");
        chk("fwd_rf", "op0", out_op0, 64'h77);
        wb_we = 1; wb_addr = 0; wb_data = 64'h99; in_rs0 = 0;
        tick("wb_r0");
        chk("wb_r0", "op0", out_op0, 64'd0);

        // Load-use bubble, then MEM forwarding of the load result
        issue_load(6);
        set_idle();
        in_valid = 1; in_rs0 = 2; in_use0 = 1; in_rs1 = 6; in_use1 = 1;
        in_rd = 8; in_we = 1;
        #1;
        chk("lu", "in_ready", 64'(in_ready), 64'd0);
        tick("lu_bubble");
        chk("lu_bubble", "valid", 64'(out_valid), 64'd0);
        chk("lu_bubble", "stall_cnt", 64'(stall_cnt), 64'd1);
        mem_valid = 1; mem_we = 1; mem_rd = 6; mem_result = 64'h5A;
        tick("lu_fwd");
        chk("lu_fwd", "op1", out_op1, 64'h5A);
        chk("lu_fwd", "valid", 64'(out_valid), 64'd1);
        issue_load(6);
        set_idle();
        in_valid = 1; in_rs0 = 1; in_use0 = 1; in_rs1 = 6; in_use1 = 0; in_rd = 8;
        tick("lu_unused");
        chk("lu_unused", "valid", 64'(out_valid), 64'd1);
        chk("lu_unused", "stall_cnt", 64'(stall_cnt), 64'd1);

        // Register 0 is never forwarded and never stalls
        issue_load(0);
        set_idle();
        ex_result = 64'hFF; in_valid = 1; in_rs0 = 0; in_use0 = 1; in_rd = 3;
        tick("zero");
        chk("zero", "op0", out_op0, 64'd0);
        chk("zero", "valid", 64'(out_valid), 64'd1);

        // Flush beats hold; hold freezes the register
        set_idle();
        in_valid = 1; in_rd = 5; in_we = 1; flush = 1; ex_hold = 1;
        tick("flush_hold");
        chk("flush_hold", "valid", 64'(out_valid), 64'd0);
        flush = 0; ex_hold = 0; in_rd = 4'hA; in_ctrl = 8'h3C;
        tick("pre_hold");
        ex_hold = 1; in_rd = 4'hB; in_ctrl = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick("hold");
            chk("hold", "in_ready", 64'(in_ready), 64'd0);
            chk("hold", "rd", 64'(out_rd), 64'hA);
            chk("hold", "ctrl", 64'(out_ctrl), 64'h3C);
        end

        // Counter saturation
        for (int i = 0; i < 16; i++) begin
            issue_load(6);
            set_idle();
            in_valid = 1; in_rs0 = 6; in_use0 = 1;
            tick("sat");
        end
        chk("sat", "stall_cnt", 64'(stall_cnt), 64'(MAXC));

        // Reset in the middle of a stall
        issue_load(6);
        set_idle();
        in_valid = 1; in_rs1 = 6; in_use1 = 1;
        #1;
        chk("rst_mid", "in_ready_pre", 64'(in_ready), 64'd0);
        async_reset("rst_mid");

        // Randomized traffic, addresses drawn from a small set for hazards
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rs0     = AW'($urandom_range(0, 5));
            in_rs1     = AW'($urandom_range(0, 5));
            in_use0    = 1'($urandom);
            in_use1    = 1'($urandom);
            in_rd      = AW'($urandom_range(0, 5));
            in_we      = 1'($urandom);
            in_is_load = ($urandom_range(0, 2) == 0);
            in_ctrl    = CW'($urandom);
            ex_result  = {$urandom, $urandom};
            mem_valid  = 1'($urandom);
            mem_we     = 1'($urandom);
            mem_rd     = AW'($urandom_range(0, 5));
            mem_result = {$urandom, $urandom};
            wb_we      = 1'($urandom);
            wb_addr    = AW'($urandom_range(0, 5));
            wb_data    = {$urandom, $urandom};
            ex_hold    = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
